// File: rtl/mycpu_pkg.sv
// mycpu_pkg: shared PC-select command encoding for the fetch unit
package mycpu_pkg;

    localparam int PC_SEL_W = 3;

    typedef enum logic [PC_SEL_W-1:0] {
        PC_HOLD   = 3'b000,
        PC_INC    = 3'b001,
        PC_BRANCH = 3'b010,
        PC_JUMP   = 3'b011,
        PC_CALL   = 3'b100,
        PC_RET    = 3'b101
    } pc_sel_e;

endpackage

// File: rtl/pc_ras_ras_stack.sv
// ras_stack: circular return-address stack with saturating count
module ras_stack #(
    parameter int PC_W      = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [PC_W-1:0]            din,
    output logic [PC_W-1:0]            top,
    output logic [$clog2(RAS_DEPTH):0] cnt,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]  mem [RAS_DEPTH];
    logic [PTR_W-1:0] wp;
    logic [PTR_W-1:0] rp;

    assign rp    = wp - PTR_W'(1);
    assign full  = cnt == CNT_W'(RAS_DEPTH);
    assign empty = cnt == '0;
    assign top   = empty ? '0 : mem[rp];

    // entry storage needs no reset; a full push simply overwrites the oldest slot
    always_ff @(posedge clk)
        if (push) mem[wp] <= din;

    // pointer and count; pops on an empty stack are ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            cnt <= '0;
        end else if (push) begin
            wp  <= wp + PTR_W'(1);
            cnt <= full ? cnt : cnt + CNT_W'(1);
        end else if (pop && !empty) begin
            wp  <= rp;
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_ras.sv
// pc_ras: program counter with integrated return-address stack
module pc_ras
    import mycpu_pkg::*;
#(
    parameter int              PC_W      = 16,
    parameter int              OFS_W     = 6,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall_in,
    input  logic [PC_SEL_W-1:0]        ps_in,
    input  logic [OFS_W-1:0]           ofs_in,
    input  logic [PC_W-1:0]            ra_in,
    input  logic                       clr_err_in,
    output logic [PC_W-1:0]            pc_out,
    output logic [PC_W-1:0]            ras_top_out,
    output logic [$clog2(RAS_DEPTH):0] ras_cnt_out,
    output logic                       ras_ovf_out,
    output logic                       ras_unf_out
);

    pc_sel_e         sel;
    logic [PC_W-1:0] ofs_ext;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_br;
    logic [PC_W-1:0] pc_nxt;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic            ovf_set;
    logic            unf_set;

    assign sel     = pc_sel_e'(ps_in);
    assign ofs_ext = {{(PC_W-OFS_W){ofs_in[OFS_W-1]}}, ofs_in};
    assign pc_inc  = pc_out + PC_W'(1);
    assign pc_br   = pc_out + ofs_ext;
    assign push    = !stall_in && sel == PC_CALL;
    assign pop     = !stall_in && sel == PC_RET && !empty;
    assign ovf_set = push && full;
    assign unf_set = !stall_in && sel == PC_RET && empty;

    // next-PC select; reserved encodings fall through to hold
    always_comb
        pc_nxt = sel == PC_INC                      ? pc_inc :
                 sel == PC_BRANCH || sel == PC_CALL ? pc_br :
                 sel == PC_JUMP                     ? ra_in :
                 sel == PC_RET                      ? (empty ? pc_inc : ras_top_out) :
                                                      pc_out;

    // PC register and sticky flags; a set event beats clear, clear works while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_out      <= RESET_PC;
            ras_ovf_out <= 1'b0;
            ras_unf_out <= 1'b0;
        end else begin
            if (!stall_in) pc_out <= pc_nxt;
            ras_ovf_out <= ovf_set | (ras_ovf_out & ~clr_err_in);
            ras_unf_out <= unf_set | (ras_unf_out & ~clr_err_in);
        end
    end

    ras_stack #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .top   (ras_top_out),
        .cnt   (ras_cnt_out),
        .full  (full),
        .empty (empty)
    );

endmodule
